// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
// The edge-pulse outputs are built only when SW_DEBOUNCE_EDGE_EN is defined.
package sw_debounce_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        WAIT   = 1'b1
    } deb_state_e;

    localparam int unsigned NB_SW_DEFAULT           = 32'd4;
    localparam int unsigned NB_COUNTER_DEFAULT      = 32'd20;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd500000;

    // Returns {rise, fall} for a level transition old_lvl -> new_lvl.
    function automatic logic [1:0] edge_of(input logic old_lvl, input logic new_lvl);
        return {new_lvl & ~old_lvl, old_lvl & ~new_lvl};
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch: two-flop synchronizer, STABLE/WAIT qualifier and accepted level.
// Edge pulse registers exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned NB_COUNTER      = NB_COUNTER_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [NB_COUNTER-1:0] CNT_ONE  = {{(NB_COUNTER-1){1'b0}}, 1'b1};

    logic                  sync1_q;
    logic                  sync2_q;
    deb_state_e            state_q;
    deb_state_e            state_d;
    logic [NB_COUNTER-1:0] cnt_q;
    logic [NB_COUNTER-1:0] cnt_d;
    logic                  level_q;
    logic                  level_d;

    // Synchronizer chain plus qualifier state, counter and accepted level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // A new level must disagree with the accepted one on DEBOUNCE_CYCLES+1 consecutive edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2_q != level_q) begin
                    state_d = WAIT;
                end else begin
                    state_d = STABLE;
                end
            end
            WAIT: begin
                if (sync2_q == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = sync2_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic       rise_q;
    logic       fall_q;
    logic [1:0] edge_s;

    // Level only moves on acceptance, so its next-state transition is the pulse.
    assign edge_s = edge_of(level_q, level_d);

    // Pulses are registered alongside the level so they line up with o_sw.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= edge_s[1];
            fall_q <= edge_s[0];
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Bank of NB_SW independent switch debouncers with optional edge pulses.
// Define SW_DEBOUNCE_EDGE_EN to build o_rise/o_fall/o_changed; otherwise they are tied low.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned NB_SW           = NB_SW_DEFAULT,
    parameter int unsigned NB_COUNTER      = NB_COUNTER_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_changed
);

    logic [NB_SW-1:0] rise_s;
    logic [NB_SW-1:0] fall_s;

    for (genvar g = 0; g < NB_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .NB_COUNTER      (NB_COUNTER),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i   (clock),
            .rst_i   (i_reset),
            .sw_i    (i_sw[g]),
            .level_o (o_sw[g]),
            .rise_o  (rise_s[g]),
            .fall_o  (fall_s[g])
        );
    end

    assign o_rise = rise_s;
    assign o_fall = fall_s;

`ifdef SW_DEBOUNCE_EDGE_EN
    assign o_changed = |(rise_s | fall_s);
`else
    assign o_changed = 1'b0;
`endif

endmodule
